// File: rtl/alu_pkg.sv
// Op encodings for the shared ALU and the arbiter FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OpFwd    = 3'b000;
    localparam logic [2:0] OpAdd    = 3'b001;
    localparam logic [2:0] OpAnd    = 3'b010;
    localparam logic [2:0] OpOr     = 3'b011;
    localparam logic [2:0] OpRshift = 3'b100;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StResp  = 2'b10
    } arb_state_e;

    // Codes above OpRshift are reserved and never reach the ALU.
    function automatic logic op_reserved(input logic [2:0] op);
        return op > OpRshift;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals of alu_arbiter; slave = arbiter side, master = environment.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [WIDTH-1:0] alu_data1;
    logic [WIDTH-1:0] alu_data2;
    logic [2:0]       alu_select;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_id;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_data1, alu_data2, alu_select,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_data1, alu_data2, alu_select,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/alu_arbiter_arb2.sv
// Two-way grant logic: round-robin when ALU_ARB_RR_EN is defined, else fixed priority to req[0].
module arb2 (
`ifdef ALU_ARB_RR_EN
    input  logic       clk,
    input  logic       resetn,
    input  logic       update,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_RR_EN
    // High when requester 1 wins the next tie.
    logic prio_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_q <= 1'b0;
        end else if (update) begin
            prio_q <= gnt[0];
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end
    end
`else
    assign gnt = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU and returns one response per operation.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ALU_LAT = 1
) (
    input logic          clk,
    input logic          resetn,
    alu_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(ALU_LAT + 1);

    arb_state_e       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             idle;
    logic             issue;
    logic             resp;
    logic             accept;
    logic [2:0]       sel_op;

    assign req    = {bus.req1_valid, bus.req0_valid};
    assign idle   = (state_q == StIdle);
    assign issue  = (state_q == StIssue);
    assign resp   = (state_q == StResp);
    assign accept = idle & (|req);
    assign sel_op = gnt[1] ? bus.req1_op : bus.req0_op;

    arb2 u_arb2 (
`ifdef ALU_ARB_RR_EN
        .clk    (clk),
        .resetn (resetn),
        .update (accept),
`endif
        .req    (req),
        .gnt    (gnt)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d  = sel_op;
                    a_d   = gnt[1] ? bus.req1_a : bus.req0_a;
                    b_d   = gnt[1] ? bus.req1_b : bus.req0_b;
                    id_d  = gnt[1];
                    cnt_d = CntW'(ALU_LAT - 1);
                    if (op_reserved(sel_op)) begin
                        res_d   = '0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                // Capture on the last cycle the ALU inputs are held.
                if (cnt_q == '0) begin
                    res_d   = bus.alu_result;
                    zero_d  = bus.alu_zero;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign bus.req0_ready = resetn & idle & gnt[0];
    assign bus.req1_ready = resetn & idle & gnt[1];

    assign bus.alu_data1  = issue ? a_q : '0;
    assign bus.alu_data2  = issue ? b_q : '0;
    assign bus.alu_select = issue ? op_q : '0;

    assign bus.rsp_valid  = resp;
    assign bus.rsp_data   = resp ? res_q : '0;
    assign bus.rsp_zero   = resp & zero_q;
    assign bus.rsp_id     = resp & id_q;
    assign bus.rsp_err    = resp & err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus random traffic against a timing model.
module tb_alu_arbiter;

    localparam int unsigned W   = 8;
    localparam int unsigned LAT = 1;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_rsp = 0;

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(
        .WIDTH   (W),
        .ALU_LAT (LAT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        case (op)
            3'd0:    return a;
            3'd1:    return a + b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a >> b;
            default: return '0;
        endcase
    endfunction

    // The bench plays the shared ALU.
    assign bus.alu_result = alu_ref(bus.alu_select, bus.alu_data1, bus.alu_data2);
    assign bus.alu_zero   = (bus.alu_result == '0);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Transaction-level model: one operation in flight, response window derived from grant cycle.
    bit             m_busy = 1'b0;
    int             m_g, m_start;
    int             last_gnt = 1;
    logic [2:0]     m_op;
    logic [W-1:0]   m_a, m_b, m_data;
    logic           m_zero, m_id, m_err;

    always @(negedge clk) begin : model
        logic         er0, er1, erv, ez, eid, eerr;
        logic [W-1:0] ed1, ed2, erd;
        logic [2:0]   esel;
        int           win;
        er0 = 0; er1 = 0; erv = 0; ez = 0; eid = 0; eerr = 0;
        ed1 = '0; ed2 = '0; erd = '0; esel = '0; win = -1;
        if (!resetn) begin
            m_busy   = 1'b0;
            last_gnt = 1;
        end else if (!m_busy) begin
            if (bus.req0_valid && bus.req1_valid) win = RR ? 1 - last_gnt : 0;
            else if (bus.req0_valid) win = 0;
            else if (bus.req1_valid) win = 1;
            er0 = (win == 0);
            er1 = (win == 1);
        end else begin
            if (!m_err && cyc > m_g && cyc <= m_g + LAT) begin
                ed1 = m_a; ed2 = m_b; esel = m_op;
            end
            if (cyc >= m_start) begin
                erv = 1; erd = m_data; ez = m_zero; eid = m_id; eerr = m_err;
            end
        end
        chk("m_req0_ready", bus.req0_ready, er0);
        chk("m_req1_ready", bus.req1_ready, er1);
        chk("m_alu_data1", bus.alu_data1, ed1);
        chk("m_alu_data2", bus.alu_data2, ed2);
        chk("m_alu_select", bus.alu_select, esel);
        chk("m_rsp_valid", bus.rsp_valid, erv);
        chk("m_rsp_data", bus.rsp_data, erd);
        chk("m_rsp_zero", bus.rsp_zero, ez);
        chk("m_rsp_id", bus.rsp_id, eid);
        chk("m_rsp_err", bus.rsp_err, eerr);
        if (resetn) begin
            if (win >= 0) begin
                m_busy   = 1'b1;
                m_g      = cyc;
                last_gnt = win;
                m_id     = (win == 1);
                m_op     = m_id ? bus.req1_op : bus.req0_op;
                m_a      = m_id ? bus.req1_a : bus.req0_a;
                m_b      = m_id ? bus.req1_b : bus.req0_b;
                m_err    = (m_op > 3'd4);
                m_data   = m_err ? '0 : alu_ref(m_op, m_a, m_b);
                m_zero   = (m_data == '0);
                m_start  = cyc + 1 + (m_err ? 0 : LAT);
            end else if (m_busy && erv && bus.rsp_ready) begin
                m_busy = 1'b0;
                n_rsp++;
            end
        end
    end

    task automatic drive(input int n, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        if (n == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit       hs0, hs1;
        int       ng, rsp_before;
        bit [3:0] exp_ord;
        resetn = 1'b0;
        bus.req0_valid = 0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);

        // Single add: 5 + 3
        edge_step();
        bus.rsp_ready = 1'b1;
        drive(0, 3'b001, 8'h05, 8'h03);
        @(negedge clk);
        chk("add_ready0", bus.req0_ready, 1);
        chk("add_ready1", bus.req1_ready, 0);
        edge_step();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("add_select", bus.alu_select, 3'b001);
        chk("add_no_rsp_yet", bus.rsp_valid, 0);
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        chk("add_rsp_valid", bus.rsp_valid, 1);
        chk("add_rsp_data", bus.rsp_data, 8'h08);
        chk("add_rsp_zero", bus.rsp_zero, 0);
        chk("add_rsp_id", bus.rsp_id, 0);
        edge_step();

        // Reserved op from requester 1
        drive(1, 3'b110, 8'h33, 8'h44);
        @(negedge clk);
        chk("rsv_ready1", bus.req1_ready, 1);
        edge_step();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("rsv_rsp_valid", bus.rsp_valid, 1);
        chk("rsv_rsp_err", bus.rsp_err, 1);
        chk("rsv_rsp_data", bus.rsp_data, 0);
        chk("rsv_rsp_zero", bus.rsp_zero, 1);
        chk("rsv_rsp_id", bus.rsp_id, 1);
        chk("rsv_alu_select", bus.alu_select, 0);
        edge_step();

        // Backpressure on an AND that yields zero
        bus.rsp_ready = 1'b0;
        drive(0, 3'b010, 8'hF0, 8'h0F);
        @(negedge clk);
        chk("bp_ready0", bus.req0_ready, 1);
        edge_step();
        bus.req0_valid = 1'b0;
        drive(1, 3'b000, 8'h5A, 8'h00);
        repeat (LAT) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_data", bus.rsp_data, 8'h00);
            chk("bp_rsp_zero", bus.rsp_zero, 1);
            chk("bp_ready0", bus.req0_ready, 0);
            chk("bp_ready1", bus.req1_ready, 0);
            edge_step();
        end
        bus.rsp_ready = 1'b1;
        edge_step();
        @(negedge clk);
        chk("bp_next_ready1", bus.req1_ready, 1);
        edge_step();
        bus.req1_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        chk("bp_fwd_data", bus.rsp_data, 8'h5A);
        chk("bp_fwd_id", bus.rsp_id, 1);
        edge_step();
        repeat (2) edge_step();

        // Both requesters held for four grants
        exp_ord = RR ? 4'b1010 : 4'b0000;
        drive(0, 3'b001, 8'h10, 8'h01);
        drive(1, 3'b001, 8'h20, 8'h02);
        ng = 0;
        for (int t = 0; t < 100 && ng < 4; t++) begin
            @(negedge clk);
            chk("both_ready_excl", bus.req0_ready & bus.req1_ready, 0);
            if (bus.req0_ready || bus.req1_ready) begin
                chk("grant_order", bus.req1_ready, exp_ord[ng]);
                ng++;
            end
            edge_step();
        end
        chk("grant_count", ng, 4);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (LAT + 4) edge_step();

        // Reset pulse during ISSUE
        drive(0, 3'b001, 8'h01, 8'h01);
        @(negedge clk);
        chk("rst_mid_ready0", bus.req0_ready, 1);
        edge_step();
        bus.req0_valid = 1'b0;
        #1;
        chk("rst_mid_issue", bus.alu_select, 3'b001);
        #1 resetn = 1'b0;
        #1;
        chk("rst_mid_select", bus.alu_select, 0);
        chk("rst_mid_data1", bus.alu_data1, 0);
        chk("rst_mid_rsp", bus.rsp_valid, 0);
        edge_step();
        resetn = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", bus.rsp_valid, 0);
        end
        edge_step();
        drive(0, 3'b011, 8'h0C, 8'h30);
        @(negedge clk);
        chk("post_rst_ready0", bus.req0_ready, 1);
        edge_step();
        bus.req0_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        chk("post_rst_rsp_valid", bus.rsp_valid, 1);
        chk("post_rst_rsp_data", bus.rsp_data, 8'h3C);
        edge_step();

        // Random traffic, checked cycle by cycle by the model
        rsp_before = n_rsp;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs0 = bus.req0_valid & bus.req0_ready;
            hs1 = bus.req1_valid & bus.req1_ready;
            edge_step();
            if (hs0 || !bus.req0_valid) begin
                if ($urandom_range(0, 2) != 0)
                    drive(0, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
                else
                    bus.req0_valid = 1'b0;
            end
            if (hs1 || !bus.req1_valid) begin
                if ($urandom_range(0, 2) != 0)
                    drive(1, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
                else
                    bus.req1_valid = 1'b0;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        chk("random_progress", (n_rsp - rsp_before) > 200, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
